z_result_stage: RTL and testbench
=================================

// Module: z_result_stage
// PURPOSE
//  Result stage directly downstream of the ALU (add32/sub32/mul/div). Captures each ALU
//  result (Zlow, optional Zhigh, c_out) into a DEPTH-entry buffer and computes status flags.
//  Streams the result onto the 32-bit datapath bus, low half then high half, under a
//  valid/ready handshake. Replaces the bare Z register so ALU issue decouples from bus use.
// PARAMETERS
//  DATA_W   32  width of one result half and of the bus
//  DEPTH    2   result-buffer entries (power of two, >=2)
// PORTS
//  clk        in   1        single clock, rising edge
//  clr        in   1        async active-low reset (0 = reset)
//  flush      in   1        sync: drop all buffered results, FSM to IDLE
//  alu_valid  in   1        ALU presents a result this cycle
//  alu_ready  out  1        stage can accept (count < DEPTH)
//  alu_zlow   in   DATA_W   result low half (sub32/add32 Zlow)
//  alu_zhigh  in   DATA_W   result high half (used only if alu_wide)
//  alu_wide   in   1        1 = 64-bit result (mul/div), 2 bus beats
//  alu_cout   in   1        ALU carry/borrow out
//  bus_valid  out  1        bus_data holds a valid beat
//  bus_ready  in   1        bus consumer takes the beat this cycle
//  bus_data   out  DATA_W   current beat
//  bus_is_hi  out  1        1 = beat is the high half
//  flag_z     out  1        last accepted result == 0 (all used bits)
//  flag_n     out  1        sign bit of last accepted result
//  flag_c     out  1        alu_cout of last accepted result
//  count      out  clog2(DEPTH)+1  buffered entries
// BEHAVIOUR
//  - Reset (clr=0, async): buffer empty, count=0, FSM IDLE, alu_ready=1 after release,
//    bus_valid=0, bus_data=0, bus_is_hi=0, flag_z/n/c=0. Reset mid-beat abandons the beat.
//  - Push: alu_valid & alu_ready at edge stores {zhigh,zlow,wide,cout}; count+1.
//    alu_ready = (count < DEPTH), registered-state only; no comb path from bus_ready
//    (a full buffer refuses a push even if a pop happens in the same cycle).
//  - Flags update on push (not pop): flag_z = (zlow==0) & (!wide | zhigh==0);
//    flag_n = wide ? zhigh[31] : zlow[31]; flag_c = cout. Held otherwise, kept over flush.
//  - Output FSM, states IDLE / SEND_LO / SEND_HI:
//    IDLE: bus_valid=0; -> SEND_LO when count>0 (next cycle).
//    SEND_LO: bus_valid=1, bus_data=head.zlow, bus_is_hi=0; on bus_ready: wide -> SEND_HI,
//      else pop head and -> SEND_LO if count>1 else IDLE.
//    SEND_HI: bus_valid=1, bus_data=head.zhigh, bus_is_hi=1; on bus_ready pop head,
//      -> SEND_LO if count>1 else IDLE.
//    bus_data/bus_is_hi stable while bus_valid & !bus_ready.
//  - Latency: push at edge N into empty stage -> bus_valid=1 in cycle N+2 (IDLE->SEND_LO).
//    Back-to-back entries stream with no bubble (SEND_LO->SEND_LO).
//  - Simultaneous push & pop (count<DEPTH): count unchanged; both take effect.
//  - Pointers wrap modulo DEPTH; count never exceeds DEPTH or underflows.
//  - flush: count=0, pointers=0, FSM IDLE, bus_valid=0 next cycle; a push in the flush cycle
//    is dropped (flush wins). A beat accepted the same cycle as flush is not repeated.
// STRUCTURE
//  - Shared package z_stage_pkg: FSM state encoding (IDLE=2'd0, SEND_LO=2'd1, SEND_HI=2'd2),
//    entry struct/width {zhigh, zlow, wide, cout} = 2*DATA_W+2.
//  - One sub-module z_result_fifo: DEPTH-entry storage, wr/rd pointers, count, full/empty.
//  - Top holds flag registers and output FSM.
// TESTING
//  1. sub32 5-5: push zlow=0x00000000, cout=1, wide=0, bus_ready=1 -> flag_z=1, flag_c=1,
//     flag_n=0; one beat bus_data=0x00000000, bus_is_hi=0; count back to 0.
//  2. Wide: zhigh=0x00000001, zlow=0xFFFFFFFE, wide=1 -> beats 0xFFFFFFFE(hi=0) then
//     0x00000001(hi=1); flag_n=0, flag_z=0.
//  3. Backpressure: bus_ready=0, push 0x11,0x22,0x33 -> alu_ready=0 after 2 pushes, 0x33
//     refused; release bus_ready -> 0x11 then 0x22 with no bubble; data held while stalled.
//  4. Reset mid SEND_HI of wide entry: clr=0 -> bus_valid=0, count=0, flags=0 immediately
//     (async); after release alu_ready=1, no stale beat.
//  5. Flush with 2 entries + concurrent push of 0x44 -> count=0, no beats, flags keep
//     values from last accepted push before flush.
//  6. Negative: zlow=0x80000000, wide=0 -> flag_n=1, flag_z=0.

Source files
------------

// File: rtl/z_stage_pkg.sv
// Shared definitions for the ALU result stage: output FSM encoding and the
// packed layout of one buffered result entry {zhigh, zlow, wide, cout}.
package z_stage_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND_LO = 2'd1,
    SEND_HI = 2'd2
  } state_e;

  // Bit offsets inside a packed entry; zhigh sits directly above zlow.
  localparam int unsigned ENT_COUT = 0;
  localparam int unsigned ENT_WIDE = 1;
  localparam int unsigned ENT_ZLO  = 2;

  localparam int unsigned DATA_W_DEF = 32;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] zhigh;
    logic [DATA_W_DEF-1:0] zlow;
    logic                  wide;
    logic                  cout;
  } z_entry_t;

  function automatic int unsigned entry_width(input int unsigned data_w);
    return 2 * data_w + 2;
  endfunction

endpackage

// File: rtl/z_result_fifo.sv
// DEPTH-entry result buffer with wrapping pointers and an occupancy count.
// Exposes the head entry and the entry behind it so the consumer can preload.
module z_result_fifo #(
  parameter int unsigned WIDTH = 66,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         head,
  output logic [WIDTH-1:0]         head_next,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q, rd_ptr_nxt;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full       = (count_q == CW'(DEPTH));
  assign do_push    = push & !full & !flush;
  assign do_pop     = pop & (count_q != '0) & !flush;
  assign rd_ptr_nxt = rd_ptr_q + PW'(1);

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_nxt;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign head      = mem_q[rd_ptr_q];
  assign head_next = mem_q[rd_ptr_nxt];
  assign count     = count_q;

endmodule

// File: rtl/z_result_stage.sv
// Result stage behind the ALU: buffers results, tracks Z/N/C status flags and
// streams each result onto the bus as a low beat plus an optional high beat.
module z_result_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   flush,
  input  logic                   alu_valid,
  output logic                   alu_ready,
  input  logic [DATA_W-1:0]      alu_zlow,
  input  logic [DATA_W-1:0]      alu_zhigh,
  input  logic                   alu_wide,
  input  logic                   alu_cout,
  output logic                   bus_valid,
  input  logic                   bus_ready,
  output logic [DATA_W-1:0]      bus_data,
  output logic                   bus_is_hi,
  output logic                   flag_z,
  output logic                   flag_n,
  output logic                   flag_c,
  output logic [$clog2(DEPTH):0] count
);
  import z_stage_pkg::*;

  localparam int unsigned EW = entry_width(DATA_W);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [EW-1:0]     wr_entry, head, head_nxt;
  logic [CW-1:0]     cnt;
  logic              full, push, pop, head_wide, more;
  logic [DATA_W-1:0] head_zlo, head_zhi, nxt_zlo;
  logic              fifo_unused;

  state_e            state_q, adv_state;
  logic              bus_valid_q, bus_is_hi_q, adv_valid;
  logic [DATA_W-1:0] bus_data_q, adv_data;
  logic              flag_z_q, flag_n_q, flag_c_q;

  assign alu_ready = !full;
  assign push      = alu_valid & !full & !flush;
  assign wr_entry  = {alu_zhigh, alu_zlow, alu_wide, alu_cout};

  assign head_zlo  = head[ENT_ZLO +: DATA_W];
  assign head_zhi  = head[ENT_ZLO + DATA_W +: DATA_W];
  assign head_wide = head[ENT_WIDE];
  assign nxt_zlo   = head_nxt[ENT_ZLO +: DATA_W];
  assign fifo_unused = ^{head[ENT_COUT], head_nxt[EW-1:ENT_ZLO + DATA_W], head_nxt[ENT_WIDE:0]};

  assign pop  = bus_ready & (((state_q == SEND_LO) & !head_wide) | (state_q == SEND_HI));
  assign more = (cnt > CW'(1));

  z_result_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .clr       (clr),
    .flush     (flush),
    .push      (push),
    .pop       (pop),
    .wdata     (wr_entry),
    .head      (head),
    .head_next (head_nxt),
    .count     (cnt),
    .full      (full)
  );

  // Outputs are registered, so when the head retires the next beat is
  // preloaded from the entry behind it rather than from the current head.
  always_comb begin
    adv_state = IDLE;
    adv_valid = 1'b0;
    adv_data  = '0;
    if (more) begin
      adv_state = SEND_LO;
      adv_valid = 1'b1;
      adv_data  = nxt_zlo;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q     <= IDLE;
      bus_valid_q <= 1'b0;
      bus_data_q  <= '0;
      bus_is_hi_q <= 1'b0;
    end else if (flush) begin
      state_q     <= IDLE;
      bus_valid_q <= 1'b0;
      bus_data_q  <= '0;
      bus_is_hi_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cnt != '0) begin
            state_q     <= SEND_LO;
            bus_valid_q <= 1'b1;
            bus_data_q  <= head_zlo;
            bus_is_hi_q <= 1'b0;
          end
        end
        SEND_LO: begin
          if (bus_ready) begin
            if (head_wide) begin
              state_q     <= SEND_HI;
              bus_data_q  <= head_zhi;
              bus_is_hi_q <= 1'b1;
            end else begin
              state_q     <= adv_state;
              bus_valid_q <= adv_valid;
              bus_data_q  <= adv_data;
              bus_is_hi_q <= 1'b0;
            end
          end
        end
        SEND_HI: begin
          if (bus_ready) begin
            state_q     <= adv_state;
            bus_valid_q <= adv_valid;
            bus_data_q  <= adv_data;
            bus_is_hi_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          bus_valid_q <= 1'b0;
          bus_data_q  <= '0;
          bus_is_hi_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      flag_z_q <= 1'b0;
      flag_n_q <= 1'b0;
      flag_c_q <= 1'b0;
    end else if (push) begin
      flag_z_q <= (alu_zlow == '0) & (!alu_wide | (alu_zhigh == '0));
      flag_n_q <= alu_wide ? alu_zhigh[DATA_W-1] : alu_zlow[DATA_W-1];
      flag_c_q <= alu_cout;
    end
  end

  assign bus_valid = bus_valid_q;
  assign bus_data  = bus_data_q;
  assign bus_is_hi = bus_is_hi_q;
  assign flag_z    = flag_z_q;
  assign flag_n    = flag_n_q;
  assign flag_c    = flag_c_q;
  assign count     = cnt;

endmodule

// File: tb/tb_z_result_stage.sv
// Directed bench for z_result_stage: a vector table for single results plus
// hand-written sequences for backpressure, reset, flush and push/pop overlap.
module tb_z_result_stage;

  logic        clk = 1'b0;
  logic        clr, flush, alu_valid, alu_ready, alu_wide, alu_cout;
  logic [31:0] alu_zlow, alu_zhigh, bus_data;
  logic        bus_valid, bus_ready, bus_is_hi, flag_z, flag_n, flag_c;
  logic [1:0]  count;

  int unsigned checks = 0;
  int unsigned failures = 0;

  always #5 clk = ~clk;

  z_result_stage #(
    .DATA_W (32),
    .DEPTH  (2)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .flush     (flush),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_zlow  (alu_zlow),
    .alu_zhigh (alu_zhigh),
    .alu_wide  (alu_wide),
    .alu_cout  (alu_cout),
    .bus_valid (bus_valid),
    .bus_ready (bus_ready),
    .bus_data  (bus_data),
    .bus_is_hi (bus_is_hi),
    .flag_z    (flag_z),
    .flag_n    (flag_n),
    .flag_c    (flag_c),
    .count     (count)
  );

  typedef struct {
    logic [31:0] zlo;
    logic [31:0] zhi;
    logic        wide;
    logic        cout;
    logic        ez;
    logic        en;
    logic        ec;
  } vec_t;

  vec_t vecs[6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] lo, input logic [31:0] hi,
                       input logic w, input logic c);
    alu_valid = v;
    alu_zlow  = lo;
    alu_zhigh = hi;
    alu_wide  = w;
    alu_cout  = c;
  endtask

  task automatic watch_no_beats(input string name, input int unsigned cycles);
    int unsigned seen;
    seen = 0;
    for (int unsigned k = 0; k < cycles; k++) begin
      if (bus_valid) seen++;
      step();
    end
    chk(name, seen, 0);
  endtask

  initial begin
    vecs[0] = '{32'h0000_0000, 32'h0000_DEAD, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{32'hFFFF_FFFE, 32'h0000_0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{32'h0000_0000, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    clr = 1'b0; flush = 1'b0; bus_ready = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    step(); step();
    chk("rst_bus_valid", bus_valid, 0);
    chk("rst_bus_data", bus_data, 0);
    chk("rst_bus_is_hi", bus_is_hi, 0);
    chk("rst_count", count, 0);
    chk("rst_flags", {flag_z, flag_n, flag_c}, 0);
    clr = 1'b1;
    step();
    chk("rst_alu_ready", alu_ready, 1);

    for (int unsigned i = 0; i < 6; i++) begin
      drive(1'b1, vecs[i].zlo, vecs[i].zhi, vecs[i].wide, vecs[i].cout);
      step();
      alu_valid = 1'b0;
      chk($sformatf("v%0d_flag_z", i), flag_z, vecs[i].ez);
      chk($sformatf("v%0d_flag_n", i), flag_n, vecs[i].en);
      chk($sformatf("v%0d_flag_c", i), flag_c, vecs[i].ec);
      chk($sformatf("v%0d_count1", i), count, 1);
      chk($sformatf("v%0d_lat_idle", i), bus_valid, 0);
      step();
      chk($sformatf("v%0d_lo_valid", i), bus_valid, 1);
      chk($sformatf("v%0d_lo_data", i), bus_data, vecs[i].zlo);
      chk($sformatf("v%0d_lo_is_hi", i), bus_is_hi, 0);
      step();
      if (vecs[i].wide) begin
        chk($sformatf("v%0d_hi_valid", i), bus_valid, 1);
        chk($sformatf("v%0d_hi_data", i), bus_data, vecs[i].zhi);
        chk($sformatf("v%0d_hi_is_hi", i), bus_is_hi, 1);
        step();
      end
      chk($sformatf("v%0d_done_valid", i), bus_valid, 0);
      chk($sformatf("v%0d_done_count", i), count, 0);
    end

    // Backpressure: two entries fill the buffer, the third is refused.
    bus_ready = 1'b0;
    drive(1'b1, 32'h11, '0, 1'b0, 1'b0);
    step();
    alu_zlow = 32'h22;
    step();
    chk("bp_full_ready", alu_ready, 0);
    chk("bp_full_count", count, 2);
    drive(1'b1, 32'h33, '0, 1'b0, 1'b1);
    step();
    alu_valid = 1'b0;
    chk("bp_refused_count", count, 2);
    chk("bp_refused_flag_c", flag_c, 0);
    step(); step();
    chk("bp_stall_valid", bus_valid, 1);
    chk("bp_stall_data", bus_data, 32'h11);
    bus_ready = 1'b1;
    step();
    chk("bp_second_valid", bus_valid, 1);
    chk("bp_second_data", bus_data, 32'h22);
    chk("bp_second_count", count, 1);
    step();
    chk("bp_drain_valid", bus_valid, 0);
    chk("bp_drain_count", count, 0);

    // Asynchronous reset while the high beat of a wide entry is stalled.
    bus_ready = 1'b0;
    drive(1'b1, 32'h1234_5678, 32'h8000_0000, 1'b1, 1'b1);
    step();
    alu_valid = 1'b0;
    chk("ar_pre_flag_n", flag_n, 1);
    step();
    bus_ready = 1'b1;
    step();
    bus_ready = 1'b0;
    chk("ar_hi_is_hi", bus_is_hi, 1);
    chk("ar_hi_data", bus_data, 32'h8000_0000);
    clr = 1'b0;
    #1;
    chk("ar_bus_valid", bus_valid, 0);
    chk("ar_count", count, 0);
    chk("ar_flags", {flag_z, flag_n, flag_c}, 0);
    #2;
    clr = 1'b1;
    bus_ready = 1'b1;
    step();
    chk("ar_alu_ready", alu_ready, 1);
    watch_no_beats("ar_no_stale_beat", 5);

    // Flush with a full buffer and a concurrent push attempt.
    bus_ready = 1'b0;
    drive(1'b1, 32'h55, '0, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h0, '0, 1'b0, 1'b1);
    step();
    chk("fl_full_count", count, 2);
    flush = 1'b1;
    drive(1'b1, 32'h44, '0, 1'b0, 1'b0);
    step();
    flush = 1'b0;
    alu_valid = 1'b0;
    chk("fl_count", count, 0);
    chk("fl_bus_valid", bus_valid, 0);
    chk("fl_flags_kept", {flag_z, flag_n, flag_c}, 3'b101);
    bus_ready = 1'b1;
    watch_no_beats("fl_no_beats", 5);

    // Flush while a beat is being accepted; push in that cycle has room but is dropped.
    drive(1'b1, 32'h66, '0, 1'b0, 1'b1);
    step();
    alu_valid = 1'b0;
    step();
    chk("fl2_beat_valid", bus_valid, 1);
    flush = 1'b1;
    drive(1'b1, 32'h44, '0, 1'b0, 1'b0);
    step();
    flush = 1'b0;
    alu_valid = 1'b0;
    chk("fl2_count", count, 0);
    chk("fl2_flags_kept", {flag_z, flag_n, flag_c}, 3'b001);
    watch_no_beats("fl2_no_repeat", 5);

    // Push and pop in the same cycle keep the count steady.
    drive(1'b1, 32'hA1, '0, 1'b0, 1'b0);
    step();
    alu_valid = 1'b0;
    step();
    chk("pp_first_data", bus_data, 32'hA1);
    drive(1'b1, 32'hB2, '0, 1'b0, 1'b0);
    step();
    alu_valid = 1'b0;
    chk("pp_count_same", count, 1);
    step();
    chk("pp_second_valid", bus_valid, 1);
    chk("pp_second_data", bus_data, 32'hB2);
    step();
    chk("pp_drain_count", count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
